modular_addsub_pipe: RTL

Multi-lane, fully pipelined modular adder/subtractor computing (a + b) mod Q or (a - b) mod Q per lane, selected per lane per transaction. It is the parametrised successor of the fixed 30-bit two-cycle modular adder. It adds configurable width, modulus and lane count, subtraction mode, valid/ready flow control with backpressure, a sideband tag and range-error flagging. It feeds NTT butterfly datapaths, where one lane adds and another subtracts in the same transaction.

---
 rtl/modular_addsub_pipe.sv | 126 ++++++++++++
 1 files changed

// File: rtl/modular_addsub_pipe.sv
// ----------------------------------------------------------------------------
// modular_addsub_pipe
//
// Multi-lane, two-stage pipelined modular adder/subtractor. Each lane computes
// (a + b) mod Q or (a - b) mod Q, chosen per lane per transaction. All lanes
// share one valid/ready handshake and one sideband tag.
//
// Stage S1 forms s = a + (sub ? Q - b : b) at WIDTH+1 bits and flags operands
// that are out of range. Stage S2 applies one conditional subtraction of Q and
// drives the outputs.
//
// Ports:
//   clk        clock, rising edge
//   rstn       asynchronous active-low reset
//   in_valid   input transaction present
//   in_ready   block accepts input this cycle (= !out_valid || out_ready)
//   in_a/in_b  operands, lane i at [i*WIDTH +: WIDTH]
//   in_sub     per-lane mode, 0 = add, 1 = subtract (a - b)
//   in_tag     sideband, returned unchanged with the result
//   out_valid  result present
//   out_ready  downstream accepts result
//   out_c      results, same packing as operands
//   out_err    per-lane flag: a >= Q or b >= Q
//   out_tag    tag of the presented result
// ----------------------------------------------------------------------------
module modular_addsub_pipe #(
   parameter int          WIDTH = 30,
   parameter logic [63:0] Q     = 64'd1063321601,
   parameter int          LANES = 1,
   parameter int          TAG_W = 8
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*WIDTH-1:0] in_a,
   input  logic [LANES*WIDTH-1:0] in_b,
   input  logic [LANES-1:0]       in_sub,
   input  logic [TAG_W-1:0]       in_tag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*WIDTH-1:0] out_c,
   output logic [LANES-1:0]       out_err,
   output logic [TAG_W-1:0]       out_tag
);

   localparam logic [WIDTH:0] QW = Q[WIDTH:0];

   // Sum at WIDTH+1 bits; subtraction is turned into addition of Q - b so the
   // sum is never negative for in-range operands (range 0..2Q-1).
   function automatic logic [WIDTH:0] mod_sum(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic             sub);
      logic [WIDTH:0] addend;
      addend = sub ? (QW - {1'b0, b}) : {1'b0, b};
      return {1'b0, a} + addend;
   endfunction

   // One conditional subtraction suffices since s < 2Q for in-range inputs.
   function automatic logic [WIDTH-1:0] mod_reduce(input logic [WIDTH:0] s);
      return (s >= QW) ? WIDTH'(s - QW) : s[WIDTH-1:0];
   endfunction

   function automatic logic range_err(input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b);
      return ({1'b0, a} >= QW) || ({1'b0, b} >= QW);
   endfunction

   logic                   advance;
   logic                   vld_p1;
   logic [WIDTH:0]         s_p1 [LANES];
   logic [LANES-1:0]       err_p1;
   logic [TAG_W-1:0]       tag_p1;
   logic                   vld_p2;
   logic [LANES*WIDTH-1:0] c_p2;
   logic [LANES-1:0]       err_p2;
   logic [TAG_W-1:0]       tag_p2;

   assign advance  = !vld_p2 || out_ready;
   assign in_ready = advance;

   // ---- S1: sum and range check ----
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_p1 <= 1'b0;
      end else if (advance) begin
         vld_p1 <= in_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (advance && in_valid) begin
         for (int i = 0; i < LANES; i++) begin
            s_p1[i]   <= mod_sum(in_a[i*WIDTH +: WIDTH], in_b[i*WIDTH +: WIDTH], in_sub[i]);
            err_p1[i] <= range_err(in_a[i*WIDTH +: WIDTH], in_b[i*WIDTH +: WIDTH]);
         end
         tag_p1 <= in_tag;
      end
   end

   // ---- S2: reduction, drives outputs ----
   // Output data is reset so the ports read 0 until the first valid result.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_p2 <= 1'b0;
         c_p2   <= '0;
         err_p2 <= '0;
         tag_p2 <= '0;
      end else if (advance) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            for (int i = 0; i < LANES; i++) begin
               c_p2[i*WIDTH +: WIDTH] <= mod_reduce(s_p1[i]);
            end
            err_p2 <= err_p1;
            tag_p2 <= tag_p1;
         end
      end
   end

   assign out_valid = vld_p2;
   assign out_c     = c_p2;
   assign out_err   = err_p2;
   assign out_tag   = tag_p2;

endmodule
